// File: rtl/lamp_conflict_monitor.sv
// lamp_conflict_monitor: independent watchdog on the pedestrian-crossing lamp lines.
// Samples the five lamp lines once, checks pattern legality, road sequencing and
// phase timing, and latches the first fault code until reset.
// Optional macro LAMP_MON_SAFE_OUT_EN adds safe_* lamp outputs that pass the lamps
// through while healthy and switch to a flashing-yellow / ped-red pattern on fault.
module lamp_conflict_monitor #(
    parameter int unsigned TIMER_SCALE  = 16000000,
    parameter int unsigned MIN_YELLOW_S = 3,
    parameter int unsigned MIN_CLEAR_S  = 2,
    parameter int unsigned MAX_PHASE_S  = 60,
    parameter int unsigned STARTUP_S    = 12
) (
    input  logic       pin3_clk_16mhz,
    input  logic       rst,
    input  logic       lamp_green,
    input  logic       lamp_yellow,
    input  logic       lamp_red,
    input  logic       lamp_ped_green,
    input  logic       lamp_ped_red,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic       monitor_active
`ifdef LAMP_MON_SAFE_OUT_EN
    ,
    output logic       safe_green,
    output logic       safe_yellow,
    output logic       safe_red,
    output logic       safe_ped_green,
    output logic       safe_ped_red
`endif
);

    localparam int unsigned TW = 32;
    localparam logic [TW-1:0] YELLOW_LIM  = TW'(MIN_YELLOW_S * TIMER_SCALE);
    localparam logic [TW-1:0] CLEAR_LIM   = TW'(MIN_CLEAR_S * TIMER_SCALE);
    localparam logic [TW-1:0] PHASE_LIM   = TW'(MAX_PHASE_S * TIMER_SCALE);
    localparam logic [TW-1:0] STARTUP_LIM = TW'(STARTUP_S * TIMER_SCALE);

    // Lamp vector layout: {ped_red, ped_green, red, yellow, green}
    localparam logic [4:0] PAT_DARK  = 5'b00000;
    localparam logic [4:0] PAT_TEST  = 5'b11111;
    localparam logic [4:0] PAT_CLEAR = 5'b10100;
    localparam logic [2:0] ROAD_G    = 3'b001;
    localparam logic [2:0] ROAD_Y    = 3'b010;
    localparam logic [2:0] ROAD_R    = 3'b100;

    typedef enum logic [1:0] {
        ST_STARTUP = 2'd0,
        ST_MONITOR = 2'd1,
        ST_FAULT   = 2'd2
    } state_t;

    state_t        state;
    logic [4:0]    lamp_d;
    logic [4:0]    lamp_q;
    logic [2:0]    road_prev;
    logic          ped_green_prev;
    logic [TW-1:0] phase_t;
    logic [TW-1:0] prev_len;
    logic [TW-1:0] clear_t;

    logic          road_ok_c;
    logic          ped_ok_c;
    logic          step_ok_c;
    logic          road_step_c;
    logic          ped_rise_c;
    logic [2:0]    chk_code_c;
    logic          set_fault_c;
    logic [2:0]    set_code_c;
    logic          enter_mon_c;

    function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
        return (v == '1) ? v : v + TW'(1);
    endfunction

    assign lamp_d = {lamp_ped_red, lamp_ped_green, lamp_red, lamp_yellow, lamp_green};

    // Sample lamps; track current-pattern age, previous-pattern length and all-red time
    always_ff @(posedge pin3_clk_16mhz) begin
        if (rst) begin
            lamp_q         <= '0;
            road_prev      <= '0;
            ped_green_prev <= 1'b0;
            phase_t        <= '0;
            prev_len       <= '0;
            clear_t        <= '0;
        end else begin
            lamp_q         <= lamp_d;
            road_prev      <= lamp_q[2:0];
            ped_green_prev <= lamp_q[3];
            if (lamp_d != lamp_q) begin
                phase_t  <= '0;
                prev_len <= sat_inc(phase_t);
            end else begin
                phase_t  <= sat_inc(phase_t);
            end
            clear_t <= (lamp_q == PAT_CLEAR) ? sat_inc(clear_t) : '0;
        end
    end

    assign road_ok_c   = $onehot(lamp_q[2:0]);
    assign ped_ok_c    = $onehot(lamp_q[4:3]);
    assign step_ok_c   = (road_prev == ROAD_G && lamp_q[2:0] == ROAD_Y) ||
                         (road_prev == ROAD_Y && lamp_q[2:0] == ROAD_R) ||
                         (road_prev == ROAD_R && lamp_q[2:0] == ROAD_G);
    assign road_step_c = (road_prev != lamp_q[2:0]) && $onehot(road_prev) && road_ok_c;
    assign ped_rise_c  = lamp_q[3] && !ped_green_prev;

    // Rule checks on the sampled pattern; later assignments win so the lowest code is kept
    always_comb begin
        chk_code_c = 3'd0;
        if (phase_t >= PHASE_LIM)                                      chk_code_c = 3'd7;
        if (ped_rise_c && (clear_t < CLEAR_LIM))                       chk_code_c = 3'd6;
        if (road_prev == ROAD_Y && lamp_q[2:0] == ROAD_R &&
            (prev_len < YELLOW_LIM))                                   chk_code_c = 3'd5;
        if (road_step_c && !step_ok_c)                                 chk_code_c = 3'd4;
        if (!ped_ok_c)                                                 chk_code_c = 3'd3;
        if (!road_ok_c)                                                chk_code_c = 3'd2;
        if (lamp_q[3] && (lamp_q[0] || lamp_q[1]))                     chk_code_c = 3'd1;
    end

    // Decide whether this cycle raises a fault or arms the monitor
    always_comb begin
        set_fault_c = 1'b0;
        set_code_c  = 3'd0;
        enter_mon_c = 1'b0;
        case (state)
            ST_STARTUP: begin
                if (lamp_q == PAT_DARK || lamp_q == PAT_TEST) begin
                    if (phase_t >= STARTUP_LIM) begin
                        set_fault_c = 1'b1;
                        set_code_c  = 3'd7;
                    end
                end else if (chk_code_c != 3'd0) begin
                    set_fault_c = 1'b1;
                    set_code_c  = chk_code_c;
                end else begin
                    enter_mon_c = 1'b1;
                end
            end
            ST_MONITOR: begin
                if (chk_code_c != 3'd0) begin
                    set_fault_c = 1'b1;
                    set_code_c  = chk_code_c;
                end
            end
            default: ;
        endcase
    end

    // Monitor FSM with registered status outputs; fault is sticky until reset
    always_ff @(posedge pin3_clk_16mhz) begin
        if (rst) begin
            state          <= ST_STARTUP;
            fault          <= 1'b0;
            fault_code     <= 3'd0;
            monitor_active <= 1'b0;
        end else if (set_fault_c) begin
            state          <= ST_FAULT;
            fault          <= 1'b1;
            fault_code     <= set_code_c;
            monitor_active <= 1'b0;
        end else if (enter_mon_c) begin
            state          <= ST_MONITOR;
            monitor_active <= 1'b1;
        end
    end

`ifdef LAMP_MON_SAFE_OUT_EN
    localparam int unsigned   HALF_RAW   = TIMER_SCALE / 2;
    localparam logic [TW-1:0] FLASH_HALF = TW'((HALF_RAW > 0) ? HALF_RAW : 1);

    logic [TW-1:0] flash_cnt;

    // Pass lamps through while healthy; on fault force ped red and flash road yellow
    always_ff @(posedge pin3_clk_16mhz) begin
        if (rst) begin
            safe_green     <= 1'b0;
            safe_yellow    <= 1'b0;
            safe_red       <= 1'b0;
            safe_ped_green <= 1'b0;
            safe_ped_red   <= 1'b0;
            flash_cnt      <= '0;
        end else if (set_fault_c || fault) begin
            safe_green     <= 1'b0;
            safe_red       <= 1'b0;
            safe_ped_green <= 1'b0;
            safe_ped_red   <= 1'b1;
            if (!fault) begin
                safe_yellow <= 1'b1;
                flash_cnt   <= '0;
            end else if (flash_cnt == FLASH_HALF - TW'(1)) begin
                safe_yellow <= ~safe_yellow;
                flash_cnt   <= '0;
            end else begin
                flash_cnt   <= flash_cnt + TW'(1);
            end
        end else begin
            {safe_ped_red, safe_ped_green, safe_red, safe_yellow, safe_green} <= lamp_q;
            flash_cnt <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_lamp_conflict_monitor.sv
// Testbench for lamp_conflict_monitor (TIMER_SCALE=10). A history-based reference
// model is stepped on every clock and compared against the DUT; directed scenarios
// add hand-computed expectations, followed by randomized lamp sequences.
// Define LAMP_MON_SAFE_OUT_EN to also exercise the safe_* outputs.
module tb_lamp_conflict_monitor;

    localparam int unsigned TS = 10;
    localparam int YEL_LIM   = 3 * TS;
    localparam int CLR_LIM   = 2 * TS;
    localparam int PHASE_LIM = 60 * TS;
    localparam int START_LIM = 12 * TS;
    localparam int HALF      = TS / 2;

    // {ped_red, ped_green, red, yellow, green}
    localparam logic [4:0] P_DARK = 5'b00000;
    localparam logic [4:0] P_TEST = 5'b11111;
    localparam logic [4:0] G_PR   = 5'b10001;
    localparam logic [4:0] Y_PR   = 5'b10010;
    localparam logic [4:0] R_PR   = 5'b10100;
    localparam logic [4:0] R_PG   = 5'b01100;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic [4:0] lamp = 5'b0;
    logic       fault;
    logic [2:0] fault_code;
    logic       monitor_active;
`ifdef LAMP_MON_SAFE_OUT_EN
    logic       safe_green, safe_yellow, safe_red, safe_ped_green, safe_ped_red;
`endif

    lamp_conflict_monitor #(.TIMER_SCALE(TS)) dut (
        .pin3_clk_16mhz (clk),
        .rst            (rst),
        .lamp_green     (lamp[0]),
        .lamp_yellow    (lamp[1]),
        .lamp_red       (lamp[2]),
        .lamp_ped_green (lamp[3]),
        .lamp_ped_red   (lamp[4]),
        .fault          (fault),
        .fault_code     (fault_code),
        .monitor_active (monitor_active)
`ifdef LAMP_MON_SAFE_OUT_EN
        ,
        .safe_green     (safe_green),
        .safe_yellow    (safe_yellow),
        .safe_red       (safe_red),
        .safe_ped_green (safe_ped_green),
        .safe_ped_red   (safe_ped_red)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // view holds every lamp pattern the monitor has sampled since the last reset.
    logic [4:0] view[$];
    int         mstate = 0;      // 0 startup, 1 monitoring, 2 faulted
    logic [2:0] mcode  = 3'd0;
    int         mage   = 0;      // cycles since fault rose
    logic [4:0] msafe  = 5'b0;

    function automatic int run_len(input int last);
        int n = 0;
        for (int i = last; i >= 0; i--) begin
            if (view[i] != view[last]) break;
            n++;
        end
        return n;
    endfunction

    function automatic int road_idx(input logic [2:0] rd);
        case (rd)
            3'b001:  return 0;
            3'b010:  return 1;
            3'b100:  return 2;
            default: return -1;
        endcase
    endfunction

    function automatic logic [2:0] rule_code();
        int sz, cur_run, prev_run, clr, rp, rc;
        logic [4:0] cur, prev;
        sz       = view.size();
        cur      = view[sz-1];
        prev     = (sz > 1) ? view[sz-2] : 5'b0;
        cur_run  = run_len(sz - 1);
        prev_run = (sz > cur_run) ? run_len(sz - 1 - cur_run) : 0;
        clr = 0;
        for (int i = sz - 2; i >= 0; i--) begin
            if (view[i] != R_PR) break;
            clr++;
        end
        rp = road_idx(prev[2:0]);
        rc = road_idx(cur[2:0]);
        if (cur[3] && (cur[0] || cur[1]))                         return 3'd1;
        if ($countones(cur[2:0]) != 1)                            return 3'd2;
        if ($countones(cur[4:3]) != 1)                            return 3'd3;
        if (rp >= 0 && rc >= 0 && rp != rc && rc != (rp + 1) % 3) return 3'd4;
        if (rp == 1 && rc == 2 && prev_run < YEL_LIM)             return 3'd5;
        if (cur[3] && !prev[3] && clr < CLR_LIM)                  return 3'd6;
        if (cur_run - 1 >= PHASE_LIM)                             return 3'd7;
        return 3'd0;
    endfunction

    task automatic model_step(input logic r, input logic [4:0] in);
        logic [4:0] cur;
        logic [2:0] c;
        logic       ybit;
        int         was_fault;
        if (r) begin
            view.delete();
            view.push_back(5'b0);
            mstate = 0; mcode = 3'd0; mage = 0; msafe = 5'b0;
            return;
        end
        cur       = view[view.size()-1];
        was_fault = (mstate == 2);
        if (mstate != 2) begin
            c = rule_code();
            if (mstate == 0 && (cur == P_DARK || cur == P_TEST)) begin
                if (run_len(view.size() - 1) - 1 >= START_LIM) begin
                    mstate = 2; mcode = 3'd7;
                end
            end else if (c != 3'd0) begin
                mstate = 2; mcode = c;
            end else begin
                mstate = 1;
            end
        end
        if (mstate == 2) begin
            mage  = was_fault ? mage + 1 : 0;
            ybit  = ((mage / HALF) % 2) == 0;
            msafe = {1'b1, 1'b0, 1'b0, ybit, 1'b0};
        end else begin
            msafe = cur;
        end
        view.push_back(in);
    endtask

    // Per-cycle comparison against the model, sampled 1 time unit after the edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            model_step(rst, lamp);
            chk("cyc_fault",  32'(fault),          32'(mstate == 2));
            chk("cyc_code",   32'(fault_code),     32'(mcode));
            chk("cyc_active", 32'(monitor_active), 32'(mstate == 1));
`ifdef LAMP_MON_SAFE_OUT_EN
            chk("cyc_safe", 32'({safe_ped_red, safe_ped_green, safe_red, safe_yellow, safe_green}),
                32'(msafe));
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [4:0] p, input int n);
        repeat (n) begin
            lamp = p;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        lamp = 5'b0;
        @(negedge clk);
        rst  = 1'b0;
    endtask

    task automatic start();
        do_reset();
        drive(P_TEST, 5);
    endtask

    task automatic pin(input string name, input logic f, input logic [2:0] c);
        chk({name, "_fault"}, 32'(fault), 32'(f));
        chk({name, "_code"},  32'(fault_code), 32'(c));
    endtask

    initial begin
        // Reset state
        do_reset();
        pin("reset", 1'b0, 3'd0);
        chk("reset_active", 32'(monitor_active), 32'd0);

        // Legal sequence, monitor arms two cycles after first green is driven
        drive(P_TEST, 50);
        drive(G_PR, 1);
        chk("arm_early", 32'(monitor_active), 32'd0);
        drive(G_PR, 1);
        chk("arm", 32'(monitor_active), 32'd1);
        drive(G_PR, 98); drive(Y_PR, 30); drive(R_PR, 20); drive(R_PG, 100); drive(R_PR, 50);
        for (int lp = 0; lp < 2; lp++) begin
            drive(G_PR, 100); drive(Y_PR, 30); drive(R_PR, 20); drive(R_PG, 100); drive(R_PR, 50);
        end
        pin("legal", 1'b0, 3'd0);
        chk("legal_active", 32'(monitor_active), 32'd1);

        // Conflict for one cycle: fault two cycles after it is driven
        drive(5'b01001, 1);
        chk("conflict_n1", 32'(fault), 32'd0);
        drive(R_PR, 1);
        pin("conflict", 1'b1, 3'd1);
`ifdef LAMP_MON_SAFE_OUT_EN
        chk("safe_rise", 32'({safe_ped_red, safe_ped_green, safe_red, safe_yellow, safe_green}),
            32'(5'b10010));
        drive(R_PR, 5);
        chk("safe_flash_off", 32'({safe_ped_red, safe_ped_green, safe_red, safe_yellow, safe_green}),
            32'(5'b10000));
        drive(R_PR, 5);
        chk("safe_flash_on", 32'(safe_yellow), 32'd1);
`endif
        for (int i = 0; i < 1000; i++) drive(5'($urandom), 1);
        pin("conflict_hold", 1'b1, 3'd1);
        chk("conflict_inactive", 32'(monitor_active), 32'd0);

        // Green straight to red
        start(); drive(G_PR, 10); drive(R_PR, 3);
        pin("skip_yellow", 1'b1, 3'd4);
        // Short yellow, then exact minimum yellow
        start(); drive(G_PR, 10); drive(Y_PR, 29); drive(R_PR, 3);
        pin("yellow29", 1'b1, 3'd5);
        start(); drive(G_PR, 10); drive(Y_PR, 30); drive(R_PR, 3);
        pin("yellow30", 1'b0, 3'd0);

        // Short clearance, then exact minimum clearance
        start(); drive(G_PR, 10); drive(Y_PR, 30); drive(R_PR, 19); drive(R_PG, 3);
        pin("clear19", 1'b1, 3'd6);
        start(); drive(G_PR, 10); drive(Y_PR, 30); drive(R_PR, 20); drive(R_PG, 3);
        pin("clear20", 1'b0, 3'd0);
        // Green held past the phase limit
        start(); drive(G_PR, 650);
        pin("long_green", 1'b1, 3'd7);

        // Road dark and both ped lamps: lowest code wins
        start(); drive(G_PR, 10); drive(5'b11000, 1); drive(G_PR, 2);
        pin("multi", 1'b1, 3'd2);
        do_reset();
        pin("rst_clear", 1'b0, 3'd0);
        chk("rst_clear_active", 32'(monitor_active), 32'd0);
        drive(P_TEST, 200);
        pin("startup_to", 1'b1, 3'd7);

        // Randomized sequences near the timing boundaries with occasional junk
        for (int rd = 0; rd < 25; rd++) begin
            do_reset();
            drive(($urandom_range(0, 1) == 1) ? P_TEST : P_DARK,
                  ($urandom_range(0, 9) == 0) ? 125 : int'($urandom_range(1, 20)));
            for (int lp = 0; lp < 4; lp++) begin
                if ($urandom_range(0, 7) == 0) drive(5'($urandom), int'($urandom_range(1, 3)));
                drive(G_PR, ($urandom_range(0, 15) == 0) ? 610 : int'($urandom_range(1, 40)));
                drive(Y_PR, int'($urandom_range(27, 33)));
                drive(R_PR, int'($urandom_range(17, 23)));
                drive(R_PG, int'($urandom_range(1, 40)));
                drive(R_PR, int'($urandom_range(1, 20)));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
